// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the shift register controller.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_counter.sv
// Shift sequencer counter: latches the effective sequence length on start,
// counts completed shifts and flags the shift that reaches the length.
module shift_seq_counter #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             shift_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] len_eff;

  // A length of zero or anything past the register width means a full-width sequence.
  always_comb begin
    len_eff = len_i;
    if ((len_i == '0) || (len_i > WIDTH_C)) begin
      len_eff = WIDTH_C;
    end
  end

  // Length latch and shift count; count is cleared only by a new start so it
  // keeps showing the final value after the sequence ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      count_q <= '0;
    end else if (start_i) begin
      len_q   <= len_eff;
      count_q <= '0;
    end else if (shift_i) begin
      count_q <= count_q + ONE_C;
    end
  end

  // Terminal count: the shift about to happen is the last one of the sequence.
  assign tc_o    = ((count_q + ONE_C) == len_q);
  assign count_o = count_q;

endmodule

// File: rtl/shift_register_ctrl.sv
// Universal shift register with built-in shift sequencer.
// Optional feature: define SHIFT_REG_ROTATE_EN to enable rotate feedback;
// without it the rotate port is ignored and the serial input is always sin.
//
// state | meaning
// IDLE  | waiting; accepts parallel load (priority) or start
// SHIFT | one shift per clock until the latched length is reached
// DONE  | one-cycle completion pulse, then back to IDLE
module shift_register_ctrl
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] p_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] shift_len,
  input  logic             rotate,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] status,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             rotate_q;
  logic             in_bit;
  logic             seq_start;
  logic             seq_shift;
  logic             seq_tc;

  shift_seq_counter #(
    .WIDTH (WIDTH)
  ) u_seq_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (seq_start),
    .shift_i (seq_shift),
    .len_i   (shift_len),
    .count_o (count),
    .tc_o    (seq_tc)
  );

`ifdef SHIFT_REG_ROTATE_EN
  // Rotate mode is captured with the rest of the sequence parameters on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rotate_q <= 1'b0;
    end else if (seq_start) begin
      rotate_q <= rotate;
    end
  end
`else
  logic unused_rotate;
  assign rotate_q      = 1'b0;
  assign unused_rotate = rotate;
`endif

  assign sout   = (dir_q == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];
  assign in_bit = rotate_q ? sout : sin;

  // State, data and latched direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state and data path; load beats start in IDLE, everything is ignored elsewhere.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dir_d     = dir_q;
    seq_start = 1'b0;
    seq_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          data_d = p_in;
        end else if (start) begin
          dir_d     = dir;
          seq_start = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        seq_shift = 1'b1;
        if (dir_q == DIR_LEFT) begin
          data_d = {data_q[WIDTH-2:0], in_bit};
        end else begin
          data_d = {in_bit, data_q[WIDTH-1:1]};
        end
        if (seq_tc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign status = data_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_shift_register_ctrl.sv
module tb_shift_register_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] p_in = '0;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic [CNT_W-1:0] shift_len = '0;
  logic             rotate = 1'b0;
  logic             sin = 1'b0;
  logic             sout;
  logic [WIDTH-1:0] status;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: register as a bit queue, index 0 = LSB.
  bit mdl[$];
  bit mdl_dir;

  always #5 clk = ~clk;

  shift_register_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .p_in      (p_in),
    .start     (start),
    .dir       (dir),
    .shift_len (shift_len),
    .rotate    (rotate),
    .sin       (sin),
    .sout      (sout),
    .status    (status),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  function automatic logic [WIDTH-1:0] mdl_vec();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i] = mdl[i];
    return v;
  endfunction

  function automatic logic mdl_sout();
    return mdl_dir ? mdl[WIDTH-1] : mdl[0];
  endfunction

  task automatic mdl_set(input logic [WIDTH-1:0] v);
    mdl.delete();
    for (int i = 0; i < WIDTH; i++) mdl.push_back(v[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (status !== '0) begin n_fail++; $display("FAIL reset_status got %h want 00", status); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if ({busy, done, sout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags busy/done/sout got %b want 000", {busy, done, sout}); end
    mdl_set('0);
    mdl_dir = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1;
    p_in = v;
    tick();
    load = 1'b0;
    mdl_set(v);
    n_cmp++; if (status !== mdl_vec()) begin n_fail++; $display("FAIL load_status got %h want %h", status, mdl_vec()); end
    n_cmp++; if (sout !== mdl_sout()) begin n_fail++; $display("FAIL load_sout got %b want %b", sout, mdl_sout()); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_busy got %b want 0", busy); end
  endtask

  // Runs one full sequence from IDLE and leaves the DUT back in IDLE.
  // sin_mode: 0 = constant 0, 1 = constant 1, 2 = random.
  task automatic run_shift(input bit d, input int len_in, input bit rot, input int sin_mode, input bit poke_done);
    int L;
    bit rot_eff;
    bit exp_out;
    bit in_b;
    bit junk;
    L = (len_in == 0 || len_in > WIDTH) ? WIDTH : len_in;
`ifdef SHIFT_REG_ROTATE_EN
    rot_eff = rot;
`else
    rot_eff = 1'b0;
`endif
    start = 1'b1;
    dir = d;
    shift_len = CNT_W'(len_in);
    rotate = rot;
    tick();
    start = 1'b0;
    mdl_dir = d;
    n_cmp++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL start_flags busy/done got %b want 10", {busy, done}); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL start_count got %0d want 0", count); end
    for (int i = 0; i < L; i++) begin
      sin = (sin_mode == 0) ? 1'b0 : (sin_mode == 1) ? 1'b1 : 1'($urandom_range(1));
      if (i == 1) begin
        load = 1'b1;
        p_in = WIDTH'($urandom);
        start = 1'b1;
        dir = ~d;
        rotate = ~rot;
      end else begin
        load = 1'b0;
        start = 1'b0;
      end
      exp_out = mdl_sout();
      n_cmp++; if (sout !== exp_out) begin n_fail++; $display("FAIL shift_sout[%0d] got %b want %b", i, sout, exp_out); end
      in_b = rot_eff ? exp_out : sin;
      if (d) begin
        junk = mdl.pop_back();
        mdl.push_front(in_b);
      end else begin
        junk = mdl.pop_front();
        mdl.push_back(in_b);
      end
      tick();
      if (i < L - 1) begin
        n_cmp++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL shift_flags[%0d] busy/done got %b want 10", i, {busy, done}); end
        n_cmp++; if (int'(count) !== i + 1) begin n_fail++; $display("FAIL shift_count[%0d] got %0d want %0d", i, count, i + 1); end
      end else begin
        n_cmp++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL done_flags busy/done got %b want 01", {busy, done}); end
        n_cmp++; if (int'(count) !== L) begin n_fail++; $display("FAIL done_count got %0d want %0d", count, L); end
        n_cmp++; if (status !== mdl_vec()) begin n_fail++; $display("FAIL done_status got %h want %h", status, mdl_vec()); end
      end
    end
    load = 1'b0;
    start = 1'b0;
    rotate = rot;
    if (poke_done) begin
      start = 1'b1;
      load = 1'b1;
      p_in = ~mdl_vec();
    end
    tick();
    start = 1'b0;
    load = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL idle_flags busy/done got %b want 00", {busy, done}); end
    n_cmp++; if (status !== mdl_vec()) begin n_fail++; $display("FAIL idle_status got %h want %h", status, mdl_vec()); end
    n_cmp++; if (int'(count) !== L) begin n_fail++; $display("FAIL idle_count got %0d want %0d", count, L); end
    n_cmp++; if (sout !== mdl_sout()) begin n_fail++; $display("FAIL idle_sout got %b want %b", sout, mdl_sout()); end
  endtask

  task automatic test_right_full();
    do_load(8'b10010010);
    run_shift(1'b0, 0, 1'b0, 0, 1'b0);
    n_cmp++; if (status !== 8'h00) begin n_fail++; $display("FAIL right_status got %h want 00", status); end
    n_cmp++; if (count !== CNT_W'(8)) begin n_fail++; $display("FAIL right_count got %0d want 8", count); end
  endtask

  task automatic test_rotate();
    logic [WIDTH-1:0] want;
`ifdef SHIFT_REG_ROTATE_EN
    want = 8'b10010010;
`else
    want = 8'b00000000;
`endif
    do_load(8'b10010010);
    run_shift(1'b0, 8, 1'b1, 0, 1'b0);
    n_cmp++; if (status !== want) begin n_fail++; $display("FAIL rotate_status got %h want %h", status, want); end
  endtask

  task automatic test_left_partial();
    do_load(8'b10010010);
    run_shift(1'b1, 3, 1'b0, 1, 1'b0);
    n_cmp++; if (status !== 8'b10010111) begin n_fail++; $display("FAIL left_status got %b want 10010111", status); end
    n_cmp++; if (count !== CNT_W'(3)) begin n_fail++; $display("FAIL left_count got %0d want 3", count); end
  endtask

  task automatic test_priority();
    load = 1'b1;
    start = 1'b1;
    p_in = 8'h5A;
    dir = ~mdl_dir;
    tick();
    load = 1'b0;
    start = 1'b0;
    mdl_set(8'h5A);
    n_cmp++; if (status !== 8'h5A) begin n_fail++; $display("FAIL prio_status got %h want 5a", status); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL prio_flags got %b want 00", {busy, done}); end
    n_cmp++; if (sout !== mdl_sout()) begin n_fail++; $display("FAIL prio_sout got %b want %b", sout, mdl_sout()); end
    tick();
    n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL prio_flags2 got %b want 00", {busy, done}); end
  endtask

  task automatic test_back_to_back();
    do_load(WIDTH'($urandom));
    run_shift(1'b1, 2, 1'b0, 2, 1'b1);
    run_shift(1'b0, 5, 1'b1, 2, 1'b0);
    run_shift(1'b1, 1, 1'b1, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_load(8'hA5);
    start = 1'b1;
    dir = 1'b0;
    shift_len = CNT_W'(8);
    rotate = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (status !== '0) begin n_fail++; $display("FAIL midrst_status got %h want 00", status); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", count); end
    n_cmp++; if ({busy, done, sout} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got %b want 000", {busy, done, sout}); end
    tick();
    rst_n = 1'b1;
    mdl_set('0);
    mdl_dir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL midrst_idle[%0d] got %b want 00", i, {busy, done}); end
      tick();
    end
    do_load(8'b10010010);
    run_shift(1'b0, 0, 1'b0, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(1) == 1) do_load(WIDTH'($urandom));
      run_shift(1'($urandom_range(1)), int'($urandom_range(0, (1 << CNT_W) - 1)),
                1'($urandom_range(1)), 2, 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_right_full();
    test_rotate();
    test_left_partial();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
